pipeline_hazard_controller: RTL

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a five-stage in-order pipeline.
// Detects load-use hazards (stall), taken branches (flush IF/ID and ID/EX)
// and HALT (drain older instructions, then hold until resume).
// Stall and flush event counters saturate at all-ones.
module pipeline_hazard_controller #(
    parameter int RegAddrBits = 3,
    parameter int DataWidth   = 16,
    parameter int DrainCycles = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   id_valid,
    input  logic [RegAddrBits-1:0] id_rs,
    input  logic [RegAddrBits-1:0] id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_halt,
    input  logic                   ex_valid,
    input  logic                   ex_is_load,
    input  logic [RegAddrBits-1:0] ex_rd,
    input  logic                   ex_branch_taken,
    input  logic                   resume,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   halted,
    output logic [DataWidth-1:0]   stall_count,
    output logic [DataWidth-1:0]   flush_count
);

    // Drain counter only has to hold DrainCycles-1.
    localparam int CntBits = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CntBits-1:0]   drain_q, drain_d;
    logic [DataWidth-1:0] stall_q, stall_d;
    logic [DataWidth-1:0] flush_q, flush_d;

    logic load_use;
    logic halt_req;
    logic stall_inc;
    logic flush_inc;

    // Register 0 is hardwired to zero, so a load into it never creates a hazard.
    assign load_use = ex_valid & ex_is_load & (ex_rd != '0) & id_valid &
                      ((id_uses_rs & (id_rs == ex_rd)) |
                       (id_uses_rt & (id_rt == ex_rd)));

    assign halt_req = id_halt & id_valid;

    // Next-state and pipeline control; branch beats load-use beats halt in RUN.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end else if (halt_req) begin
                    // Let HALT move into EX while fetch stops behind it.
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    state_d    = DRAIN;
                    drain_d    = CntBits'(DrainCycles - 1);
                end
            end
            DRAIN: begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (drain_q == '0) begin
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            HALTED: begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Saturating event counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && (stall_q != '1)) begin
            stall_d = stall_q + DataWidth'(1);
        end
        if (flush_inc && (flush_q != '1)) begin
            flush_d = flush_q + DataWidth'(1);
        end
    end

    // State and counter registers; reset overrides everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            drain_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign halted      = (state_q == HALTED);
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule
